// File: rtl/mips_core_pkg.sv
// Shared core types for the MIPS pipeline.
// Holds the branch direction encoding, the architectural address type and the
// commit-queue entry layout used by commit_queue.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef logic [31:0] Address;

    localparam int CQ_DEPTH = 8;

    // One reorder-buffer slot. recovery_target is only meaningful once done
    // is set on a branch entry.
    typedef struct packed {
        logic         valid;
        logic         done;
        logic         is_branch;
        BranchOutcome prediction;
        BranchOutcome outcome;
        Address       recovery_target;
    } cq_entry_t;

endpackage

// File: rtl/commit_queue.sv
// In-order commit queue (reorder buffer) between rename/issue and retirement.
// Entries are allocated at the tail, marked done by execute writeback and
// retired from the head in program order, at most one per cycle.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   alloc_valid/is_branch/prediction rename-side allocation request
//   alloc_tag                        tag the next allocation receives (tail)
//   wb_valid/tag/outcome/recovery_target  execute writeback
//   retire_valid, retire_tag         head entry retiring this cycle
//   count, queue_overflow            occupancy and full flag
//   C_branch_result_*                result of a retiring branch
//   commit_hc_stall, commit_hc_flush hazard-control feedback
module commit_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH = CQ_DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_valid,
    input  logic               alloc_is_branch,
    input  BranchOutcome       alloc_prediction,
    output logic [TAG_W-1:0]   alloc_tag,
    input  logic               wb_valid,
    input  logic [TAG_W-1:0]   wb_tag,
    input  BranchOutcome       wb_outcome,
    input  Address             wb_recovery_target,
    output logic               retire_valid,
    output logic [TAG_W-1:0]   retire_tag,
    output logic [TAG_W:0]     count,
    output logic               queue_overflow,
    output logic               C_branch_result_valid,
    output BranchOutcome       C_branch_result_prediction,
    output BranchOutcome       C_branch_result_outcome,
    output Address             C_branch_result_recovery_target,
    input  logic               commit_hc_stall,
    input  logic               commit_hc_flush
);

    cq_entry_t          entries_r [DEPTH];
    logic [TAG_W-1:0]   head_r;
    logic [TAG_W-1:0]   tail_r;
    logic [TAG_W:0]     count_r;

    cq_entry_t          head_entry_s;
    logic               alloc_fire_s;
    logic               retire_fire_s;
    logic [TAG_W:0]     count_next_s;

    // Fire conditions and next occupancy. Retirement deliberately ignores
    // flush so the retire outputs do not loop back through hazard control.
    always_comb begin
        head_entry_s   = entries_r[head_r];
        queue_overflow = (count_r == (TAG_W+1)'(DEPTH));
        alloc_fire_s   = alloc_valid & ~queue_overflow & ~commit_hc_flush;
        retire_fire_s  = head_entry_s.valid & head_entry_s.done & ~commit_hc_stall;
        if (commit_hc_flush) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + (TAG_W+1)'(alloc_fire_s) - (TAG_W+1)'(retire_fire_s);
        end
    end

    // Retire and branch-result outputs; branch fields read as zero when idle.
    always_comb begin
        retire_valid = retire_fire_s;
        retire_tag   = head_r;
        alloc_tag    = tail_r;
        count        = count_r;
        if (retire_fire_s && head_entry_s.is_branch) begin
            C_branch_result_valid           = 1'b1;
            C_branch_result_prediction      = head_entry_s.prediction;
            C_branch_result_outcome         = head_entry_s.outcome;
            C_branch_result_recovery_target = head_entry_s.recovery_target;
        end else begin
            C_branch_result_valid           = 1'b0;
            C_branch_result_prediction      = NOT_TAKEN;
            C_branch_result_outcome         = NOT_TAKEN;
            C_branch_result_recovery_target = '0;
        end
    end

    // Head/tail pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (commit_hc_flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (alloc_fire_s) begin
                tail_r <= tail_r + TAG_W'(1'b1);
            end else begin
                tail_r <= tail_r;
            end
            if (retire_fire_s) begin
                head_r <= head_r + TAG_W'(1'b1);
            end else begin
                head_r <= head_r;
            end
            count_r <= count_next_s;
        end
    end

    // Entry array. Allocation only targets an invalid slot (tail of a non-full
    // queue), so it can never collide with a writeback or the retiring head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
        end else if (commit_hc_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid && (wb_tag == TAG_W'(i)) && entries_r[i].valid) begin
                    entries_r[i].done            <= 1'b1;
                    entries_r[i].outcome         <= wb_outcome;
                    entries_r[i].recovery_target <= wb_recovery_target;
                end
                if (alloc_fire_s && (tail_r == TAG_W'(i))) begin
                    entries_r[i].valid           <= 1'b1;
                    entries_r[i].done            <= 1'b0;
                    entries_r[i].is_branch       <= alloc_is_branch;
                    entries_r[i].prediction      <= alloc_prediction;
                    entries_r[i].outcome         <= NOT_TAKEN;
                    entries_r[i].recovery_target <= '0;
                end else if (retire_fire_s && (head_r == TAG_W'(i))) begin
                    entries_r[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_queue.sv
// Self-checking bench for commit_queue: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_commit_queue;
    import mips_core_pkg::*;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic               clk;
    logic               rst_n;
    logic               alloc_valid;
    logic               alloc_is_branch;
    BranchOutcome       alloc_prediction;
    logic [TAG_W-1:0]   alloc_tag;
    logic               wb_valid;
    logic [TAG_W-1:0]   wb_tag;
    BranchOutcome       wb_outcome;
    Address             wb_recovery_target;
    logic               retire_valid;
    logic [TAG_W-1:0]   retire_tag;
    logic [TAG_W:0]     count;
    logic               queue_overflow;
    logic               br_valid;
    BranchOutcome       br_pred;
    BranchOutcome       br_out;
    Address             br_tgt;
    logic               stall;
    logic               flush;

    // Second instance at DEPTH=4 for the wrap-around sequence.
    logic               d4_alloc_valid;
    logic [1:0]         d4_alloc_tag;
    logic               d4_wb_valid;
    logic [1:0]         d4_wb_tag;
    logic               d4_retire_valid;
    logic [1:0]         d4_retire_tag;
    logic [2:0]         d4_count;
    logic               d4_overflow;
    logic               d4_br_valid;
    BranchOutcome       d4_br_pred;
    BranchOutcome       d4_br_out;
    Address             d4_br_tgt;

    commit_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_is_branch(alloc_is_branch),
        .alloc_prediction(alloc_prediction), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_outcome(wb_outcome),
        .wb_recovery_target(wb_recovery_target),
        .retire_valid(retire_valid), .retire_tag(retire_tag),
        .count(count), .queue_overflow(queue_overflow),
        .C_branch_result_valid(br_valid), .C_branch_result_prediction(br_pred),
        .C_branch_result_outcome(br_out), .C_branch_result_recovery_target(br_tgt),
        .commit_hc_stall(stall), .commit_hc_flush(flush)
    );

    commit_queue #(.DEPTH(4), .TAG_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(d4_alloc_valid), .alloc_is_branch(1'b0),
        .alloc_prediction(NOT_TAKEN), .alloc_tag(d4_alloc_tag),
        .wb_valid(d4_wb_valid), .wb_tag(d4_wb_tag), .wb_outcome(NOT_TAKEN),
        .wb_recovery_target(32'h0000_0000),
        .retire_valid(d4_retire_valid), .retire_tag(d4_retire_tag),
        .count(d4_count), .queue_overflow(d4_overflow),
        .C_branch_result_valid(d4_br_valid), .C_branch_result_prediction(d4_br_pred),
        .C_branch_result_outcome(d4_br_out), .C_branch_result_recovery_target(d4_br_tgt),
        .commit_hc_stall(1'b0), .commit_hc_flush(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: live entries in program order.
    typedef struct {
        int          tag;
        bit          done;
        bit          br;
        bit          pred;
        bit          out;
        logic [31:0] tgt;
    } ment_t;

    ment_t q[$];
    int    ntag;
    int    n_vec;
    int    n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit m_retire();
        return (q.size() > 0) && q[0].done && !stall;
    endfunction

    task automatic check_model();
        bit er;
        er = m_retire();
        chk("m_alloc_tag", 32'(alloc_tag), 32'(ntag));
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_overflow", 32'(queue_overflow), 32'(q.size() == DEPTH));
        chk("m_retire_valid", 32'(retire_valid), 32'(er));
        if (er) begin
            chk("m_retire_tag", 32'(retire_tag), 32'(q[0].tag));
            chk("m_br_valid", 32'(br_valid), 32'(q[0].br));
            if (q[0].br) begin
                chk("m_br_pred", 32'(br_pred), 32'(q[0].pred));
                chk("m_br_out", 32'(br_out), 32'(q[0].out));
                chk("m_br_tgt", br_tgt, q[0].tgt);
            end
        end else begin
            chk("m_br_valid_idle", 32'(br_valid), 32'd0);
        end
    endtask

    task automatic model_edge();
        bit    af;
        bit    rf;
        ment_t e;
        af = alloc_valid && (q.size() < DEPTH) && !flush;
        rf = m_retire();
        if (flush) begin
            q.delete();
            ntag = 0;
        end else begin
            if (wb_valid) begin
                foreach (q[k]) begin
                    if (q[k].tag == int'(wb_tag)) begin
                        q[k].done = 1'b1;
                        q[k].out  = wb_outcome;
                        q[k].tgt  = wb_recovery_target;
                    end
                end
            end
            if (rf) void'(q.pop_front());
            if (af) begin
                e.tag  = ntag;
                e.done = 1'b0;
                e.br   = alloc_is_branch;
                e.pred = alloc_prediction;
                e.out  = 1'b0;
                e.tgt  = 32'h0;
                q.push_back(e);
                ntag = (ntag + 1) % DEPTH;
            end
        end
    endtask

    // Called at posedge+1 (or +2) with inputs set: compare, advance model, clock.
    task automatic step();
        #2;
        check_model();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid        = 1'b0;
        alloc_is_branch    = 1'b0;
        alloc_prediction   = NOT_TAKEN;
        wb_valid           = 1'b0;
        wb_tag             = '0;
        wb_outcome         = NOT_TAKEN;
        wb_recovery_target = 32'h0;
        stall              = 1'b0;
        flush              = 1'b0;
        d4_alloc_valid     = 1'b0;
        d4_wb_valid        = 1'b0;
        d4_wb_tag          = '0;
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_retire_valid", 32'(retire_valid), 32'd0);
        chk("rst_br_valid", 32'(br_valid), 32'd0);
        chk("rst_overflow", 32'(queue_overflow), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        q.delete();
        ntag = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          cand[$];
        int          d4_exp[6];
        int          d4_n;
        n_vec = 0;
        n_err = 0;
        ntag  = 0;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // In-order retirement with out-of-order writeback 2,0,1.
        alloc_valid = 1'b1;
        repeat (3) step();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd2;
        step();
        wb_tag = 3'd0;
        #1; chk("io_wait", 32'(retire_valid), 32'd0);
        step();
        wb_tag = 3'd1;
        #1; chk("io_rv0", 32'(retire_valid), 32'd1); chk("io_tag0", 32'(retire_tag), 32'd0);
        step();
        wb_valid = 1'b0;
        #1; chk("io_rv1", 32'(retire_valid), 32'd1); chk("io_tag1", 32'(retire_tag), 32'd1);
        step();
        #1; chk("io_rv2", 32'(retire_valid), 32'd1); chk("io_tag2", 32'(retire_tag), 32'd2);
        step();
        #1; chk("io_empty_rv", 32'(retire_valid), 32'd0); chk("io_empty_cnt", 32'(count), 32'd0);
        step();

        // Reset mid-run with three live entries and a retirement presented.
        alloc_valid = 1'b1; alloc_is_branch = 1'b1; alloc_prediction = TAKEN;
        repeat (3) step();
        alloc_valid = 1'b0; alloc_is_branch = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd3; wb_outcome = TAKEN; wb_recovery_target = 32'h0000_1234;
        step();
        wb_valid = 1'b0;
        #1; chk("mid_rv", 32'(retire_valid), 32'd1); chk("mid_br", 32'(br_valid), 32'd1);
        do_reset();

        // Fill to DEPTH, drop the ninth allocation, then drain one.
        alloc_valid = 1'b1;
        repeat (8) step();
        #1;
        chk("full_count", 32'(count), 32'd8);
        chk("full_ovf", 32'(queue_overflow), 32'd1);
        chk("full_tag", 32'(alloc_tag), 32'd0);
        step();
        alloc_valid = 1'b0;
        #1; chk("drop_count", 32'(count), 32'd8); chk("drop_tag", 32'(alloc_tag), 32'd0);
        wb_valid = 1'b1; wb_tag = 3'd0;
        step();
        wb_valid = 1'b0;
        #1;
        chk("drain_rv", 32'(retire_valid), 32'd1);
        chk("drain_tag", 32'(retire_tag), 32'd0);
        chk("drain_ovf_still", 32'(queue_overflow), 32'd1);
        step();
        #1; chk("drain_ovf", 32'(queue_overflow), 32'd0); chk("drain_count", 32'(count), 32'd7);
        step();

        // Correctly predicted taken branch: one-cycle branch result.
        do_reset();
        alloc_valid = 1'b1; alloc_is_branch = 1'b1; alloc_prediction = TAKEN;
        step();
        alloc_valid = 1'b0; alloc_is_branch = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_outcome = TAKEN; wb_recovery_target = 32'h0040_0100;
        step();
        wb_valid = 1'b0;
        #1;
        chk("br_valid", 32'(br_valid), 32'd1);
        chk("br_pred", 32'(br_pred), 32'(TAKEN));
        chk("br_out", 32'(br_out), 32'(TAKEN));
        chk("br_tgt", br_tgt, 32'h0040_0100);
        step();
        #1; chk("br_once", 32'(br_valid), 32'd0);
        step();

        // Mispredicted head branch with two younger entries, flushed.
        do_reset();
        alloc_valid = 1'b1; alloc_is_branch = 1'b1; alloc_prediction = TAKEN;
        step();
        alloc_is_branch = 1'b0; alloc_prediction = NOT_TAKEN;
        repeat (2) step();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_outcome = NOT_TAKEN; wb_recovery_target = 32'h0040_0020;
        step();
        wb_tag = 3'd1; wb_outcome = TAKEN; flush = 1'b1; alloc_valid = 1'b1;
        #1;
        chk("fl_rv", 32'(retire_valid), 32'd1);
        chk("fl_tag", 32'(retire_tag), 32'd0);
        chk("fl_br_valid", 32'(br_valid), 32'd1);
        chk("fl_br_pred", 32'(br_pred), 32'(TAKEN));
        chk("fl_br_out", 32'(br_out), 32'(NOT_TAKEN));
        chk("fl_br_tgt", br_tgt, 32'h0040_0020);
        step();
        flush = 1'b0; wb_valid = 1'b0; alloc_valid = 1'b0;
        #1;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_tail", 32'(alloc_tag), 32'd0);
        chk("fl_rv_after", 32'(retire_valid), 32'd0);
        step();

        // Randomized traffic; hazard control flushes on a mispredicted retirement.
        for (int c = 0; c < 600; c++) begin
            alloc_valid        = ($urandom_range(0, 99) < 60);
            alloc_is_branch    = ($urandom_range(0, 99) < 40);
            alloc_prediction   = BranchOutcome'($urandom_range(0, 1));
            stall              = ($urandom_range(0, 99) < 20);
            wb_outcome         = BranchOutcome'($urandom_range(0, 1));
            wb_recovery_target = $urandom();
            cand.delete();
            foreach (q[k]) if (!q[k].done) cand.push_back(k);
            if (cand.size() > 0 && $urandom_range(0, 99) < 65) begin
                wb_valid = 1'b1;
                wb_tag   = TAG_W'(q[cand[$urandom_range(0, cand.size() - 1)]].tag);
            end else if (q.size() < DEPTH && $urandom_range(0, 99) < 15) begin
                wb_valid = 1'b1;
                wb_tag   = TAG_W'(ntag);
            end else begin
                wb_valid = 1'b0;
            end
            flush = m_retire() && q[0].br && (q[0].pred != q[0].out);
            step();
        end
        idle_inputs();
        step();

        // DEPTH=4: tags wrap 0,1,2,3,0,1 and occupancy stays within 4.
        d4_exp = '{0, 1, 2, 3, 0, 1};
        d4_n   = 0;
        for (int c = 0; c < 8; c++) begin
            d4_alloc_valid = (c < 6);
            d4_wb_valid    = (c >= 1) && (c <= 6);
            d4_wb_tag      = 2'((c + 3) % 4);
            #2;
            chk("d4_count_le4", 32'(d4_count <= 3'd4), 32'd1);
            if (d4_retire_valid) begin
                if (d4_n < 6) chk("d4_retire_tag", 32'(d4_retire_tag), 32'(d4_exp[d4_n]));
                d4_n++;
            end
            @(posedge clk);
            #1;
        end
        chk("d4_retire_total", 32'(d4_n), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
